sd_dat_tx_ctrl: RTL
===================

Name: sd_dat_tx_ctrl

Overview:
- Sequencer for a single-DAT-line SD block write.
- Frames each block as: start bit, BLK_BYTES data bytes MSB-first, CRC16 MSB-first, end bit.
- Drives the external serial CRC16 unit through its rst/en/serial-shift controls and reads back crc[15].
- After the end bit it releases the line, parses the card's CRC status token, waits out busy, and reports the result to the host-side command FSM.

Parameters:
BLK_BYTES, 512, data bytes per block (1..4095).
BUSY_TIMEOUT, 65535, max ticks waited for status start bit plus busy release.
TO_W, 16, timeout counter width; must satisfy 2^TO_W > BUSY_TIMEOUT.

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
tick  in  1  SD bit strobe (one per SD clock period); all line activity advances only on tick cycles
start  in  1  request block transfer; sampled in IDLE only
wr_data  in  8  next data byte
wr_valid  in  1  wr_data valid
wr_ready  out  1  holding register empty
dat_i  in  1  DAT0 input from pad
dat_o  out  1  DAT0 output
dat_oe  out  1  DAT0 output enable
crc_rst  out  1  CRC unit reset
crc_en  out  1  CRC unit absorb-bit
crc_bit  out  1  bit fed to CRC unit
crc_shift  out  1  CRC unit serial-shift request
crc_msb  in  1  CRC unit crc[15]
busy  out  1  high whenever state != IDLE
done  out  1  one-clk completion pulse
status  out  3  latched CRC status token bits
err  out  2  0 ok, 1 CRC rejected, 2 timeout, 3 underrun

Behaviour:
- Reset values: dat_o=1, dat_oe=0, busy=0, done=0, status=0, err=0, wr_ready=1, crc_rst=0, crc_en=0, crc_shift=0. Holding register is emptied; state goes to IDLE.
- Reset mid-transfer aborts immediately with the same values; no done pulse is issued.
- Byte path:
  - One holding register plus an 8-bit shift register.
  - wr_ready = holding register empty. A byte is accepted on wr_valid && wr_ready in any state, including IDLE (prefetch).
  - Holding-to-shift transfer happens on the tick that consumes bit 7 of the previous byte, or on the START tick for byte 0.
- States: IDLE, START, DATA, CRC, END, REL, ST_WAIT, ST_BITS, ST_END, BUSY_W.
- IDLE:
  - start -> START. crc_rst is pulsed for 1 clk in the same cycle.
  - start while busy=1 is ignored.
- START (first tick): dat_o<=0, dat_oe<=1, load byte 0, -> DATA.
  - If the holding register is empty at this tick: underrun.
- DATA, each tick:
  - dat_o <= shift[7]; crc_en=1 and crc_bit=shift[7], both combinational in the same cycle.
  - Shift left; bit counter increments.
  - After BLK_BYTES*8 ticks -> CRC.
  - Byte boundary with empty holding register: underrun.
- CRC, each tick: dat_o <= crc_msb, crc_shift=1 combinational. After 16 ticks -> END.
- END (tick): dat_o<=1 -> REL.
- REL (tick): dat_oe<=0, timeout counter cleared -> ST_WAIT.
- ST_WAIT: dat_i==0 on tick -> ST_BITS.
- ST_BITS: 3 ticks, shifting dat_i into status MSB-first -> ST_END.
- ST_END: ignore one tick -> BUSY_W.
- BUSY_W: dat_i==1 on tick -> done.
- Completion:
  - done=1 for 1 clk, then -> IDLE.
  - err=0 if status==3'b010, else err=1.
- Timeout:
  - The counter increments on every tick in ST_WAIT..BUSY_W.
  - Reaching BUSY_TIMEOUT -> done with err=2; status is left at its partial value.
- Underrun: dat_oe<=0, dat_o<=1, done with err=3, -> IDLE. The CRC unit is not advanced on the failing tick.
- Outside DATA/CRC, crc_en and crc_shift are never asserted.
- tick=0 freezes all line and state activity; the byte handshake continues.
- status and err hold until the next start.

Optional Feature:
- SD_DAT_TX_BLKLEN_EN defined:
  - Adds input blk_len[11:0], sampled at start acceptance.
  - The block length is the sampled value.
  - blk_len==0 or > 4095 is rejected: start is ignored and busy stays 0.
- SD_DAT_TX_BLKLEN_EN undefined: the block length is fixed at BLK_BYTES and there is no blk_len port.

Test Plan:
- BLK_BYTES=4; prefetch bytes 0x01,0x02,0x04,0x08; start; tick every cycle; card returns token 0,010,1, 2 ticks busy, then 1:
  - line shows 0, 32 data bits, CRC16 = the CRC-16/XMODEM value of the 4 bytes MSB-first, then 1;
  - done=1 with err=0, status=3'b010.
- Same block, card token 101 -> err=1, status=3'b101.
- Card never drives low, BUSY_TIMEOUT=20 -> done exactly 20 ticks after REL, err=2, dat_oe=0.
- Only 2 of 4 bytes supplied -> underrun at bit 16: err=3, dat_oe=0, crc_en count=16.
- tick asserted every 4th cycle -> identical line sequence and CRC to the first scenario; done timing scales ×4.
- rst asserted mid-DATA -> next cycle: dat_oe=0, busy=0, wr_ready=1, no done pulse; a new start afterwards completes normally.

Source files
------------

// File: rtl/sd_dat_tx_ctrl.sv
// sd_dat_tx_ctrl: single-DAT-line SD block-write sequencer.
// Frames start bit, data bytes MSB-first, CRC16 from an external serial CRC
// unit, end bit; then parses the card CRC status token and waits out busy.
// Optional: define SD_DAT_TX_BLKLEN_EN to add a run-time blk_len input.
module sd_dat_tx_ctrl #(
    parameter int unsigned BLK_BYTES    = 512,
    parameter int unsigned BUSY_TIMEOUT = 65535,
    parameter int unsigned TO_W         = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       start,
`ifdef SD_DAT_TX_BLKLEN_EN
    input  logic [11:0] blk_len,
`endif
    input  logic [7:0] wr_data,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic       dat_i,
    output logic       dat_o,
    output logic       dat_oe,
    output logic       crc_rst,
    output logic       crc_en,
    output logic       crc_bit,
    output logic       crc_shift,
    input  logic       crc_msb,
    output logic       busy,
    output logic       done,
    output logic [2:0] status,
    output logic [1:0] err
);

    typedef enum logic [3:0] {
        IDLE, START, DATA, CRC, END, REL, ST_WAIT, ST_BITS, ST_END, BUSY_W
    } state_t;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(BUSY_TIMEOUT - 1);

    state_t          state, state_nx;
    logic [7:0]      hold_data;
    logic            hold_full;
    logic [7:0]      shift_q;
    logic            shift_valid;
    logic [14:0]     bit_cnt;
    logic [14:0]     last_bit;
    logic [TO_W-1:0] to_cnt;
    logic            start_ok;
    logic            start_acc;
    logic            byte_take;
    logic            to_hit;
    logic            underrun;
    logic            timeout;
    logic            finish;
    logic [1:0]      fin_err;

`ifdef SD_DAT_TX_BLKLEN_EN
    logic [11:0] len_q;

    assign start_ok = start && (blk_len != 12'd0);
    assign last_bit = {len_q - 12'd1, 3'b111};

    // Block length captured when a transfer is accepted
    always_ff @(posedge clk) begin
        if (rst)
            len_q <= 12'(BLK_BYTES);
        else if (start_acc)
            len_q <= blk_len;
    end
`else
    assign start_ok = start;
    assign last_bit = 15'(BLK_BYTES * 8 - 1);
`endif

    assign start_acc = (state == IDLE) && start_ok;
    assign to_hit    = (to_cnt == TO_LAST);
    assign wr_ready  = !hold_full;
    assign busy      = (state != IDLE);
    assign crc_rst   = !rst && start_acc;
    assign crc_en    = !rst && tick && (state == DATA) && shift_valid;
    assign crc_shift = !rst && tick && (state == CRC);
    assign crc_bit   = shift_q[7];

    // Holding register is consumed at START and on bit 7 of every non-final byte
    assign byte_take = tick && hold_full &&
                       ((state == START) ||
                        ((state == DATA) && shift_valid &&
                         (bit_cnt[2:0] == 3'd7) && (bit_cnt != last_bit)));

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Next-state and completion decode
    always_comb begin
        state_nx = state;
        underrun = 1'b0;
        timeout  = 1'b0;
        finish   = 1'b0;
        fin_err  = 2'd0;
        case (state)
            IDLE:    if (start_ok) state_nx = START;
            START:   if (tick) begin
                         if (!hold_full) underrun = 1'b1;
                         else            state_nx = DATA;
                     end
            DATA:    if (tick) begin
                         if (!shift_valid)            underrun = 1'b1;
                         else if (bit_cnt == last_bit) state_nx = CRC;
                     end
            CRC:     if (tick && (bit_cnt == 15'd15)) state_nx = END;
            END:     if (tick) state_nx = REL;
            REL:     if (tick) state_nx = ST_WAIT;
            ST_WAIT: if (tick) begin
                         if (to_hit)     timeout  = 1'b1;
                         else if (!dat_i) state_nx = ST_BITS;
                     end
            ST_BITS: if (tick) begin
                         if (to_hit)                  timeout  = 1'b1;
                         else if (bit_cnt == 15'd2)   state_nx = ST_END;
                     end
            ST_END:  if (tick) begin
                         if (to_hit) timeout  = 1'b1;
                         else        state_nx = BUSY_W;
                     end
            BUSY_W:  if (tick) begin
                         if (dat_i) begin
                             finish  = 1'b1;
                             fin_err = (status == 3'b010) ? 2'd0 : 2'd1;
                         end else if (to_hit) begin
                             timeout = 1'b1;
                         end
                     end
            default: state_nx = IDLE;
        endcase
        if (underrun) begin
            finish  = 1'b1;
            fin_err = 2'd3;
        end
        if (timeout) begin
            finish  = 1'b1;
            fin_err = 2'd2;
        end
        if (finish)
            state_nx = IDLE;
    end

    // Host byte handshake; runs regardless of tick or state
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_full <= 1'b0;
        end else if (byte_take) begin
            hold_full <= 1'b0;
        end else if (wr_valid && !hold_full) begin
            hold_full <= 1'b1;
            hold_data <= wr_data;
        end
    end

    // Data shifter; shift_valid drops when no byte was available at a boundary
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_valid <= 1'b0;
        end else if ((state == START) && tick && hold_full) begin
            shift_q     <= hold_data;
            shift_valid <= 1'b1;
        end else if ((state == DATA) && tick && shift_valid) begin
            if (bit_cnt[2:0] == 3'd7) begin
                if (byte_take) shift_q <= hold_data;
                else           shift_valid <= 1'b0;
            end else begin
                shift_q <= {shift_q[6:0], 1'b0};
            end
        end
    end

    // Shared bit counter for data, CRC and status-token phases
    always_ff @(posedge clk) begin
        if (rst)
            bit_cnt <= '0;
        else if (state_nx != state)
            bit_cnt <= '0;
        else if (tick && ((state == DATA) || (state == CRC) || (state == ST_BITS)))
            bit_cnt <= bit_cnt + 15'd1;
    end

    // DAT0 line driver
    always_ff @(posedge clk) begin
        if (rst || underrun) begin
            dat_o  <= 1'b1;
            dat_oe <= 1'b0;
        end else if (tick) begin
            case (state)
                START: begin
                    dat_o  <= 1'b0;
                    dat_oe <= 1'b1;
                end
                DATA:    dat_o  <= shift_q[7];
                CRC:     dat_o  <= crc_msb;
                END:     dat_o  <= 1'b1;
                REL:     dat_oe <= 1'b0;
                default: ;
            endcase
        end
    end

    // Busy/status timeout counter, armed when the line is released
    always_ff @(posedge clk) begin
        if (rst)
            to_cnt <= '0;
        else if (tick && (state == REL))
            to_cnt <= '0;
        else if (tick && ((state == ST_WAIT) || (state == ST_BITS) ||
                          (state == ST_END)  || (state == BUSY_W)))
            to_cnt <= to_cnt + 1'b1;
    end

    // Result reporting: status/err held until the next accepted start
    always_ff @(posedge clk) begin
        if (rst) begin
            status <= '0;
            err    <= '0;
            done   <= 1'b0;
        end else begin
            done <= finish;
            if (start_acc) begin
                status <= '0;
                err    <= '0;
            end else begin
                if ((state == ST_BITS) && tick && !finish)
                    status <= {status[1:0], dat_i};
                if (finish)
                    err <= fin_err;
            end
        end
    end

endmodule
